// File: rtl/spi_byte_rx_pkg.sv
// Shared types and defaults for the SPI byte receiver (spi_byte_rx) and its buffer.
package spi_rx_pkg;
  localparam int BYTE_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [BYTE_W_DEF-1:0] byte_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;
endpackage

// File: rtl/spi_byte_rx_sync_fifo.sv
// sync_fifo: first-word fall-through buffer; a push while full (without a pop) is dropped.
module sync_fifo
  import spi_rx_pkg::*;
#(
  parameter int WIDTH = BYTE_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a full buffer can still accept.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI receiver (sck/sdi/load) assembling MSB-first bytes into a FWFT buffer.
// Optional macro SPI_RX_SYNC_EN adds a 2-flop synchronizer on sck, sdi and load.
module spi_byte_rx
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int BYTE_W     = BYTE_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          sdi,
  input  logic                          load,
  output logic [BYTE_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [0:0]                    dbg_state
);
  localparam int CW = $clog2(BYTE_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_W - 1);
  localparam logic [0:0]    S_IDLE   = IDLE;
  localparam logic [0:0]    S_SHIFT  = SHIFT;

  logic sck_s, sdi_s, load_s;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] sck_sync, sdi_sync, load_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      sdi_sync  <= {sdi_sync[0], sdi};
      load_sync <= {load_sync[0], load};
    end
  end

  assign sck_s  = sck_sync[1];
  assign sdi_s  = sdi_sync[1];
  assign load_s = load_sync[1];
`else
  assign sck_s  = sck;
  assign sdi_s  = sdi;
  assign load_s = load;
`endif

  logic sck_q, sck_q2, sdi_q, load_q, load_q2;
  logic sck_rise, load_rise, load_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q   <= 1'b0;
      sck_q2  <= 1'b0;
      sdi_q   <= 1'b0;
      load_q  <= 1'b0;
      load_q2 <= 1'b0;
    end else begin
      sck_q   <= sck_s;
      sck_q2  <= sck_q;
      sdi_q   <= sdi_s;
      load_q  <= load_s;
      load_q2 <= load_q;
    end
  end

  // sdi_q is captured on the same clk as the sck_q sample that reveals the rise.
  assign sck_rise  = sck_q & ~sck_q2;
  assign load_rise = load_q & ~load_q2;
  assign load_fall = ~load_q & load_q2;

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [BYTE_W-1:0] sr;
  logic              push_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  // The completed byte stays in sr until the next sck rise, at least 4 clk away,
  // so the buffer writes sr on the clk after the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sr        <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_rise) begin
            state <= S_SHIFT;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        S_SHIFT: begin
          if (load_fall) begin
            if (cnt != '0) frame_err <= 1'b1;
            cnt   <= '0;
            sr    <= '0;
            state <= S_IDLE;
          end else if (sck_rise) begin
            sr <= {sr[BYTE_W-2:0], sdi_q};
            if (cnt == LAST_BIT) begin
              cnt    <= '0;
              push_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake: out_data is valid whenever out_valid is high; a byte is consumed
  // on any clk edge where out_valid && out_ready, and out_data is held until then.
  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .pop   (pop),
    .wdata (sr),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );
endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: scenario tasks plus a scoreboard monitor on out_data.
module tb_spi_byte_rx;
  import spi_rx_pkg::*;

  localparam int DEPTH  = 4;
  localparam int BW     = 8;
  localparam int SETTLE = 8;
`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sck;
  logic          sdi;
  logic          load;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic [2:0]    level;
  logic          overflow;
  logic          frame_err;
  logic [0:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_exp;

  spi_byte_rx #(.FIFO_DEPTH(DEPTH), .BYTE_W(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .sdi       (sdi),
    .load      (load),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  // scoreboard: every accepted byte must match the oldest expected byte
  always @(negedge clk) begin
    #2;
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got %02h, nothing expected", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %02h expected %02h", out_data, mon_exp);
        end
      end
    end
  end

  // drivers (entered and left on a negedge)
  task automatic send_bit(input logic b);
    sck = 1'b0;
    sdi = b;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [BW-1:0] v);
    for (int i = BW - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic frame_start();
    load = 1'b1;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic frame_end();
    sck = 1'b0;
    repeat (2) @(negedge clk);
    load = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    load = 1'b0;
    sck = 1'b0;
    sdi = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes never delivered, expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL %s_level_after_drain: got %0d expected 0", name, level);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    load = 1'b0;
    sck = 1'b0;
    sdi = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %02h expected 00", out_data); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b expected 0", frame_err); end
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state: got %b expected IDLE", dbg_state); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_sck();
    load = 1'b0;
    send_byte(8'hFF);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    checks += 2;
    if (level !== 3'd0) begin errors++; $display("FAIL idle_sck_level: got %0d expected 0", level); end
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL idle_sck_state: got %b expected IDLE", dbg_state); end
  endtask

  task automatic test_single();
    logic [BW-1:0] v;
    int lat;
    v = 8'hA5;
    out_ready = 1'b1;
    exp_q.push_back(v);
    frame_start();
    for (int i = BW - 1; i >= 1; i--) send_bit(v[i]);
    sck = 1'b0;
    sdi = v[0];
    repeat (2) @(negedge clk);
    sck = 1'b1;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL single_latency: got %0d clk expected %0d clk", lat, LAT); end
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_one_cycle: got %b expected 0", out_valid); end
    if (level !== 3'd0) begin errors++; $display("FAIL single_level: got %0d expected 0", level); end
    frame_end();
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b expected 0", overflow); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b expected 0", frame_err); end
    wait_drain("single");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    frame_start();
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b));
      if (b <= DEPTH) exp_q.push_back(8'(b));
    end
    frame_end();
    checks += 3;
    if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ovf_frame_err: got %b expected 0", frame_err); end
    out_ready = 1'b1;
    wait_drain("ovf");
    out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_frame_err();
    apply_reset();
    frame_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    frame_end();
    checks += 3;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
    if (level !== 3'd0) begin errors++; $display("FAIL ferr_level: got %0d expected 0", level); end
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL ferr_state: got %b expected IDLE", dbg_state); end
    out_ready = 1'b1;
    exp_q.push_back(8'h3C);
    frame_start();
    send_byte(8'h3C);
    frame_end();
    wait_drain("ferr");
    checks += 2;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL ferr_overflow: got %b expected 0", overflow); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back_full();
    logic [BW-1:0] v;
    apply_reset();
    frame_start();
    for (int b = 8'h10; b <= 8'h13; b++) begin
      send_byte(8'(b));
      exp_q.push_back(8'(b));
    end
    v = 8'h14;
    exp_q.push_back(v);
    for (int i = BW - 1; i >= 1; i--) send_bit(v[i]);
    sck = 1'b0;
    sdi = v[0];
    repeat (2) @(negedge clk);
    sck = 1'b1;
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL full_level_before: got %0d expected 4", level); end
    // out_ready high only for the clk edge on which the last byte is pushed
    repeat (LAT) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks += 2;
    if (level !== 3'd4) begin errors++; $display("FAIL full_level_after: got %0d expected 4", level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b expected 0", overflow); end
    frame_end();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_end: got %b expected 0", overflow); end
    out_ready = 1'b1;
    wait_drain("full");
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    frame_start();
    send_byte(8'h55);
    send_byte(8'hAA);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    checks++;
    if (level !== 3'd2) begin errors++; $display("FAIL midrst_level_before: got %0d expected 2", level); end
    reset = 1'b0;
    load = 1'b0;
    sck = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    if (level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", level); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_out_data: got %02h expected 00", out_data); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL midrst_state: got %b expected IDLE", dbg_state); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL midrst_level_release: got %0d expected 0", level); end
    out_ready = 1'b1;
    exp_q.push_back(8'h81);
    frame_start();
    send_byte(8'h81);
    frame_end();
    wait_drain("midrst");
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err_after: got %b expected 0", frame_err); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_sck();
    test_single();
    test_overflow();
    test_frame_err();
    test_back_to_back_full();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d bytes left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4; receive-buffer depth in bytes, power of two, 2..16.
- REQ-002: Parameter BYTE_W, default 8; bits per received word.
- REQ-003: clk  input  1  system clock; the only clock.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: sck  input  1  serial clock from the upstream send_bytes master; data is sampled on its rising edge.
- REQ-006: sdi  input  1  serial data, MSB first.
- REQ-007: load  input  1  frame enable; high for the whole of a multi-byte frame.
- REQ-008: out_data  output  BYTE_W  head-of-buffer byte.
- REQ-009: out_valid  output  1  out_data holds a valid byte.
- REQ-010: out_ready  input  1  consumer accepts out_data.
- REQ-011: level  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
- REQ-012: overflow  output  1  sticky flag; a byte was dropped because the buffer was full.
- REQ-013: frame_err  output  1  sticky flag; load fell while a byte was incomplete.

Function
- REQ-014: The block SHALL detect rising edges of sck and load, and the falling edge of load, from clk-sampled copies. sck high and low times are each at least 2 clk.
- REQ-015: The state machine SHALL have two states, IDLE and SHIFT. Reset state is IDLE.
- REQ-016: IDLE -> SHIFT on a load rising edge: bit counter = 0, shift register = 0.
- REQ-017: In SHIFT, each detected sck rise SHALL shift sdi into the LSB and increment the counter.
- REQ-018: On the BYTE_W-th bit, the counter SHALL wrap to 0 and the assembled byte SHALL be pushed on the next clk. The state stays SHIFT, so back-to-back bytes need no gap.
- REQ-019: Load falling with counter = 0 SHALL give SHIFT -> IDLE with no error.
- REQ-020: Load falling with counter != 0 SHALL discard the partial byte, set frame_err and go to IDLE.
- REQ-021: An sck rise in the same cycle as a load fall SHALL be ignored.
- REQ-022: An sck rise while in IDLE SHALL be ignored.
- REQ-023: Buffer behaviour: first-word fall-through FIFO. out_valid = (level != 0). out_data = oldest byte.
- REQ-024: A pop SHALL occur when out_valid && out_ready.
- REQ-025: Push with the buffer full and no pop: drop the byte, set overflow, leave contents unchanged.
- REQ-026: Push and pop in the same cycle when full: both SHALL succeed, level unchanged, no overflow.
- REQ-027: Push and pop in the same cycle when empty: the byte is pushed and out_valid rises the next cycle. There is no bypass.
- REQ-028: Latency: out_valid SHALL rise 2 clk after the 8th sck rise is detected, with the buffer previously empty.
- REQ-029: Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
- REQ-030: While reset = 0: state IDLE; counter, shift register and pointers = 0; level = 0; out_valid = 0; out_data = 0; overflow = 0; frame_err = 0.
- REQ-031: Reset asserted mid-byte or mid-frame SHALL discard all data.
- REQ-032: After release, the block SHALL wait for a new load rising edge.
- REQ-033: The sticky flags SHALL clear only on reset.

Configuration
- REQ-034: Macro SPI_RX_SYNC_EN defined: sck, sdi and load SHALL each pass through a 2-flop synchronizer before edge detection. REQ-028 latency increases by 2 clk.
- REQ-035: Macro SPI_RX_SYNC_EN undefined: inputs SHALL go straight to the single-flop edge-detect stage, for same-clock use with send_bytes.

Structure
- REQ-036: Package spi_rx_pkg SHALL hold: BYTE_W default; typedef byte_t; state enum rx_state_t {IDLE, SHIFT}; FIFO_DEPTH default.
- REQ-037: The FIFO SHALL be a sub-module, sync_fifo, parameterised by width and depth, with push, pop, full, empty and level ports.

Verification
- REQ-038: Frame of one byte 0xA5, out_ready = 1 -> out_data = 0xA5 with out_valid for 1 cycle; level returns to 0; no flags set.
- REQ-039: Frame of 5 bytes 0x01..0x05, out_ready = 0 -> level = 4 and overflow = 1. Then out_ready = 1 -> 0x01, 0x02, 0x03, 0x04 appear in order; 0x05 never appears.
- REQ-040: Load drops after 3 bits of 0xFF -> frame_err = 1, level = 0. The next frame 0x3C is received correctly.
- REQ-041: Reset pulled low after 5 bits, with 2 bytes buffered -> all outputs 0. After release, frame 0x81 -> out_data = 0x81.
- REQ-042: Buffer full (0x10..0x13); push 0x14 in the same cycle as a pop -> overflow = 0, level = 4. Drain gives 0x11, 0x12, 0x13, 0x14.
- REQ-043: Run scenarios REQ-038 to REQ-042 both with and without SPI_RX_SYNC_EN. Check the REQ-028 latency, plus 2 clk when the macro is defined.
